// File: rtl/multdiv_ctrl_if.sv
// Bundle between the X-stage sequencer, the pipeline control and the shared multiplier/divider.
// master: the sequencer; slave: the pipeline and multdiv side that drive it.
interface multdiv_ctrl_if;
    logic [31:0] instruction_x;
    logic        valid_x;
    logic        flush_x;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] md_result;
    logic        md_ready;
    logic        md_exception;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall;
    logic        result_valid;
    logic [31:0] result_out;
    logic [4:0]  rd_out;
    logic        exc_out;
    logic [31:0] rstatus_code;
    logic        busy;

    modport master (
        input  instruction_x, valid_x, flush_x, operand_a, operand_b,
               md_result, md_ready, md_exception,
        output ctrl_mult, ctrl_div, md_a, md_b, stall, result_valid,
               result_out, rd_out, exc_out, rstatus_code, busy
    );

    modport slave (
        output instruction_x, valid_x, flush_x, operand_a, operand_b,
               md_result, md_ready, md_exception,
        input  ctrl_mult, ctrl_div, md_a, md_b, stall, result_valid,
               result_out, rd_out, exc_out, rstatus_code, busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer: launches mul/div on the shared multi-cycle unit, stalls the
// pipeline until ready or timeout, then presents the result for one cycle.
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_ctrl_if.master       io_md
);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned RD_W    = 5;
    localparam logic [4:0]  ALU_MUL = 5'b00110;
    localparam logic [4:0]  ALU_DIV = 5'b00111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_op_div,       w_op_div_nxt;
    logic [XLEN-1:0]   r_md_a,         w_md_a_nxt;
    logic [XLEN-1:0]   r_md_b,         w_md_b_nxt;
    logic [RD_W-1:0]   r_rd,           w_rd_nxt;
    logic [XLEN-1:0]   r_result,       w_result_nxt;
    logic              r_exc,          w_exc_nxt;
    logic [XLEN-1:0]   r_rstatus,      w_rstatus_nxt;
    logic [CNT_W-1:0]  r_cnt,          w_cnt_nxt;
    logic              r_ctrl_mult,    w_ctrl_mult_nxt;
    logic              r_ctrl_div,     w_ctrl_div_nxt;
    logic              r_result_valid, w_result_valid_nxt;
    logic              r_busy,         w_busy_nxt;

    logic              w_rtype;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_launch;
    logic              w_timeout;
    logic [XLEN-1:0]   w_exc_code;
    logic              w_unused_instr_bits;

    // Decode; launch is gated by reset so stall drops the moment reset asserts
    assign w_rtype    = (io_md.instruction_x[31:27] == 5'b00000);
    assign w_is_mul   = w_rtype && (io_md.instruction_x[6:2] == ALU_MUL);
    assign w_is_div   = w_rtype && (io_md.instruction_x[6:2] == ALU_DIV);
    assign w_launch   = reset && (r_state == S_IDLE) && io_md.valid_x && !io_md.flush_x
                        && (w_is_mul || w_is_div);
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_exc_code = r_op_div ? XLEN'(5) : XLEN'(4);

    assign w_unused_instr_bits = ^{io_md.instruction_x[21:7], io_md.instruction_x[1:0]};

    // State register and all registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_op_div       <= 1'b0;
            r_md_a         <= '0;
            r_md_b         <= '0;
            r_rd           <= '0;
            r_result       <= '0;
            r_exc          <= 1'b0;
            r_rstatus      <= '0;
            r_cnt          <= '0;
            r_ctrl_mult    <= 1'b0;
            r_ctrl_div     <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_op_div       <= w_op_div_nxt;
            r_md_a         <= w_md_a_nxt;
            r_md_b         <= w_md_b_nxt;
            r_rd           <= w_rd_nxt;
            r_result       <= w_result_nxt;
            r_exc          <= w_exc_nxt;
            r_rstatus      <= w_rstatus_nxt;
            r_cnt          <= w_cnt_nxt;
            r_ctrl_mult    <= w_ctrl_mult_nxt;
            r_ctrl_div     <= w_ctrl_div_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt        = r_state;
        w_op_div_nxt       = r_op_div;
        w_md_a_nxt         = r_md_a;
        w_md_b_nxt         = r_md_b;
        w_rd_nxt           = r_rd;
        w_result_nxt       = r_result;
        w_exc_nxt          = r_exc;
        w_rstatus_nxt      = r_rstatus;
        w_cnt_nxt          = r_cnt;
        w_ctrl_mult_nxt    = 1'b0;
        w_ctrl_div_nxt     = 1'b0;
        w_result_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_md_a_nxt      = io_md.operand_a;
                    w_md_b_nxt      = io_md.operand_b;
                    w_rd_nxt        = io_md.instruction_x[26:22];
                    w_op_div_nxt    = w_is_div;
                    w_ctrl_mult_nxt = !w_is_div;
                    w_ctrl_div_nxt  = w_is_div;
                    w_state_nxt     = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (io_md.md_ready) begin
                    w_result_nxt       = io_md.md_result;
                    w_exc_nxt          = io_md.md_exception;
                    w_rstatus_nxt      = io_md.md_exception ? w_exc_code : '0;
                    w_result_valid_nxt = 1'b1;
                    w_state_nxt        = S_DONE;
                end else if (w_timeout) begin
                    w_result_nxt       = '0;
                    w_exc_nxt          = 1'b1;
                    w_rstatus_nxt      = w_exc_code;
                    w_result_valid_nxt = 1'b1;
                    w_state_nxt        = S_DONE;
                end
            end
            S_DONE: begin
                // exception status is only meaningful alongside the completion strobe
                w_exc_nxt     = 1'b0;
                w_rstatus_nxt = '0;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign io_md.stall        = w_launch || (r_state == S_START) || (r_state == S_WAIT);
    assign io_md.busy         = r_busy;
    assign io_md.ctrl_mult    = r_ctrl_mult;
    assign io_md.ctrl_div     = r_ctrl_div;
    assign io_md.md_a         = r_md_a;
    assign io_md.md_b         = r_md_b;
    assign io_md.result_valid = r_result_valid;
    assign io_md.result_out   = r_result;
    assign io_md.rd_out       = r_rd;
    assign io_md.exc_out      = r_exc;
    assign io_md.rstatus_code = r_rstatus;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: mul, div-by-zero, timeout, back-to-back, reset abort,
// and non-launching instructions.
module tb_multdiv_ctrl;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam logic [4:0] ALU_ADD = 5'b00000;

    logic clock;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_stall  = 0;
    int   n_rv     = 0;
    int   n_pmul   = 0;
    int   n_pdiv   = 0;
    int   n_both   = 0;
    int   s_stall, s_rv, s_pmul, s_pdiv;

    multdiv_ctrl_if dut_if ();

    multdiv_ctrl #(.TIMEOUT(40)) dut (
        .clock (clock),
        .reset (reset),
        .io_md (dut_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Per-cycle event counts, sampled mid-cycle
    always @(negedge clock) begin
        if (dut_if.stall)                       n_stall++;
        if (dut_if.result_valid)                n_rv++;
        if (dut_if.ctrl_mult)                   n_pmul++;
        if (dut_if.ctrl_div)                    n_pdiv++;
        if (dut_if.ctrl_mult && dut_if.ctrl_div) n_both++;
    end

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd,
                                       input logic [4:0] alu);
        return {opc, rd, 15'd0, alu, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic snap();
        s_stall = n_stall; s_rv = n_rv; s_pmul = n_pmul; s_pdiv = n_pdiv;
    endtask

    task automatic launch(input logic [4:0] alu, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b);
        dut_if.instruction_x = mk(5'b00000, rd, alu);
        dut_if.valid_x       = 1'b1;
        dut_if.flush_x       = 1'b0;
        dut_if.operand_a     = a;
        dut_if.operand_b     = b;
    endtask

    initial begin
        dut_if.instruction_x = '0;
        dut_if.valid_x       = 1'b0;
        dut_if.flush_x       = 1'b0;
        dut_if.operand_a     = '0;
        dut_if.operand_b     = '0;
        dut_if.md_result     = '0;
        dut_if.md_ready      = 1'b0;
        dut_if.md_exception  = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_stall", 32'(dut_if.stall), 32'd0);
        check("rst_busy",  32'(dut_if.busy), 32'd0);
        check("rst_ctrl",  32'({dut_if.ctrl_mult, dut_if.ctrl_div}), 32'd0);
        check("rst_rv",    32'({dut_if.result_valid, dut_if.exc_out}), 32'd0);
        check("rst_res",   dut_if.result_out | 32'(dut_if.rd_out) | dut_if.rstatus_code, 32'd0);
        check("rst_ops",   dut_if.md_a | dut_if.md_b, 32'd0);
        cyc(2);
        reset = 1'b1;
        cyc(1);

        // mul 6*7, ready three cycles after the start pulse
        launch(ALU_MUL, 5'd9, 32'd6, 32'd7);
        snap();
        #1;
        check("mul_L_stall", 32'(dut_if.stall), 32'd1);
        check("mul_L_busy",  32'(dut_if.busy), 32'd0);
        cyc(1);
        check("mul_start_cm", 32'(dut_if.ctrl_mult), 32'd1);
        check("mul_start_cd", 32'(dut_if.ctrl_div), 32'd0);
        check("mul_md_a", dut_if.md_a, 32'd6);
        check("mul_md_b", dut_if.md_b, 32'd7);
        dut_if.operand_a = 32'd99;
        dut_if.flush_x   = 1'b1;
        cyc(3);
        check("mul_wait_cm", 32'(dut_if.ctrl_mult), 32'd0);
        check("mul_wait_flush_stall", 32'(dut_if.stall), 32'd1);
        dut_if.md_ready  = 1'b1;
        dut_if.md_result = 32'd42;
        cyc(1);
        dut_if.md_ready      = 1'b0;
        dut_if.flush_x       = 1'b0;
        dut_if.instruction_x = mk(5'b00000, 5'd1, ALU_ADD);
        #1;
        check("mul_done_rv",   32'(dut_if.result_valid), 32'd1);
        check("mul_done_res",  dut_if.result_out, 32'd42);
        check("mul_done_rd",   32'(dut_if.rd_out), 32'd9);
        check("mul_done_exc",  32'(dut_if.exc_out), 32'd0);
        check("mul_done_rsc",  dut_if.rstatus_code, 32'd0);
        check("mul_done_stall", 32'(dut_if.stall), 32'd0);
        check("mul_done_md_a", dut_if.md_a, 32'd6);
        cyc(1);
        check("mul_after_rv",   32'(dut_if.result_valid), 32'd0);
        check("mul_after_busy", 32'(dut_if.busy), 32'd0);
        check("mul_stall_cycles", 32'(n_stall - s_stall), 32'd5);
        check("mul_rv_cycles",    32'(n_rv - s_rv), 32'd1);
        check("mul_pulses",       32'(n_pmul - s_pmul), 32'd1);
        check("mul_no_div",       32'(n_pdiv - s_pdiv), 32'd0);

        // div 10/0: ready pulse in START must be ignored, exception reported later
        launch(ALU_DIV, 5'd3, 32'd10, 32'd0);
        snap();
        #1;
        check("div_L_stall", 32'(dut_if.stall), 32'd1);
        cyc(1);
        check("div_start_cd", 32'(dut_if.ctrl_div), 32'd1);
        check("div_start_cm", 32'(dut_if.ctrl_mult), 32'd0);
        dut_if.md_ready  = 1'b1;
        dut_if.md_result = 32'd77;
        cyc(1);
        dut_if.md_ready  = 1'b0;
        #1;
        check("div_start_ready_ignored", 32'(dut_if.result_valid), 32'd0);
        check("div_wait_stall", 32'(dut_if.stall), 32'd1);
        cyc(1);
        dut_if.md_ready     = 1'b1;
        dut_if.md_exception = 1'b1;
        dut_if.md_result    = 32'd0;
        cyc(1);
        dut_if.md_ready      = 1'b0;
        dut_if.md_exception  = 1'b0;
        dut_if.valid_x       = 1'b0;
        #1;
        check("div_done_rv",  32'(dut_if.result_valid), 32'd1);
        check("div_done_exc", 32'(dut_if.exc_out), 32'd1);
        check("div_done_rsc", dut_if.rstatus_code, 32'd5);
        check("div_done_rd",  32'(dut_if.rd_out), 32'd3);
        check("div_done_res", dut_if.result_out, 32'd0);
        cyc(1);
        check("div_pulses",  32'(n_pdiv - s_pdiv), 32'd1);
        check("div_no_mult", 32'(n_pmul - s_pmul), 32'd0);

        // mul with md_ready held low: forced completion at L+42
        launch(ALU_MUL, 5'd17, 32'd3, 32'd4);
        snap();
        cyc(41);
        check("to_pre_rv",    32'(dut_if.result_valid), 32'd0);
        check("to_pre_stall", 32'(dut_if.stall), 32'd1);
        cyc(1);
        dut_if.valid_x = 1'b0;
        #1;
        check("to_done_rv",  32'(dut_if.result_valid), 32'd1);
        check("to_done_res", dut_if.result_out, 32'd0);
        check("to_done_exc", 32'(dut_if.exc_out), 32'd1);
        check("to_done_rsc", dut_if.rstatus_code, 32'd4);
        check("to_done_rd",  32'(dut_if.rd_out), 32'd17);
        check("to_stall_cycles", 32'(n_stall - s_stall), 32'd42);
        cyc(1);

        // back-to-back mul then div
        launch(ALU_MUL, 5'd1, 32'd11, 32'd12);
        cyc(2);
        dut_if.md_ready  = 1'b1;
        dut_if.md_result = 32'd132;
        cyc(1);
        dut_if.md_ready = 1'b0;
        launch(ALU_DIV, 5'd2, 32'd100, 32'd7);
        #1;
        check("b2b_done1_rv",  32'(dut_if.result_valid), 32'd1);
        check("b2b_done1_res", dut_if.result_out, 32'd132);
        check("b2b_done1_stall", 32'(dut_if.stall), 32'd0);
        cyc(1);
        check("b2b_relaunch_stall", 32'(dut_if.stall), 32'd1);
        check("b2b_relaunch_cd",    32'(dut_if.ctrl_div), 32'd0);
        cyc(1);
        check("b2b_start2_cd", 32'(dut_if.ctrl_div), 32'd1);
        check("b2b_md_a2", dut_if.md_a, 32'd100);
        check("b2b_md_b2", dut_if.md_b, 32'd7);
        cyc(1);
        dut_if.md_ready  = 1'b1;
        dut_if.md_result = 32'd14;
        cyc(1);
        dut_if.md_ready = 1'b0;
        dut_if.valid_x  = 1'b0;
        #1;
        check("b2b_done2_rv",  32'(dut_if.result_valid), 32'd1);
        check("b2b_done2_res", dut_if.result_out, 32'd14);
        check("b2b_done2_rd",  32'(dut_if.rd_out), 32'd2);
        check("b2b_done2_exc", 32'(dut_if.exc_out), 32'd0);
        cyc(1);

        // reset during WAIT, then a fresh mul
        launch(ALU_MUL, 5'd4, 32'd1, 32'd2);
        cyc(2);
        #1 reset = 1'b0;
        #1;
        snap();
        check("rstw_stall", 32'(dut_if.stall), 32'd0);
        check("rstw_busy",  32'(dut_if.busy), 32'd0);
        check("rstw_ctrl",  32'({dut_if.ctrl_mult, dut_if.ctrl_div, dut_if.result_valid}), 32'd0);
        cyc(2);
        check("rstw_no_rv", 32'(n_rv - s_rv), 32'd0);
        reset = 1'b1;
        launch(ALU_MUL, 5'd4, 32'd5, 32'd5);
        #1;
        check("rstw_relaunch_stall", 32'(dut_if.stall), 32'd1);
        cyc(1);
        check("rstw_start_cm", 32'(dut_if.ctrl_mult), 32'd1);
        cyc(2);
        dut_if.md_ready  = 1'b1;
        dut_if.md_result = 32'd25;
        cyc(1);
        dut_if.md_ready = 1'b0;
        dut_if.valid_x  = 1'b0;
        #1;
        check("rstw_done_rv",  32'(dut_if.result_valid), 32'd1);
        check("rstw_done_res", dut_if.result_out, 32'd25);
        check("rstw_done_rd",  32'(dut_if.rd_out), 32'd4);
        cyc(1);

        // instructions that must never launch: add, bubble, flushed mul, non-R-type
        for (int p = 0; p < 4; p++) begin
            launch((p == 0) ? ALU_ADD : ALU_MUL, 5'd6, 32'd2, 32'd3);
            if (p == 1) dut_if.valid_x = 1'b0;
            if (p == 2) dut_if.flush_x = 1'b1;
            if (p == 3) dut_if.instruction_x = mk(5'b00100, 5'd6, ALU_MUL);
            snap();
            #1;
            check($sformatf("nolaunch%0d_stall", p), 32'(dut_if.stall), 32'd0);
            cyc(2);
            check($sformatf("nolaunch%0d_busy", p),  32'(dut_if.busy), 32'd0);
            check($sformatf("nolaunch%0d_stallcyc", p), 32'(n_stall - s_stall), 32'd0);
            check($sformatf("nolaunch%0d_pulses", p),
                  32'((n_pmul - s_pmul) + (n_pdiv - s_pdiv)), 32'd0);
        end
        dut_if.valid_x = 1'b0;
        dut_if.flush_x = 1'b0;

        check("ctrl_never_both", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Execute-stage sequencer for the shared multi-cycle multiplier/divider unit in the 5-stage pipeline.
- Detects `mul`/`div` in X, captures operands, fires a one-cycle start pulse and holds the pipeline stalled until the unit reports ready or a timeout expires.
- Hands the result, destination register and exception status to the X/M latch for one cycle.

## Interface
Parameters:
- TIMEOUT, 40, WAIT-state cycles before forced completion; counter width = ceil(log2(TIMEOUT+1))

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- instruction_x  in  32  instruction currently in X
- valid_x  in  1  X holds a real instruction (not a bubble)
- flush_x  in  1  X instruction is being squashed this cycle
- operand_a, operand_b  in  32 each  bypassed X operands
- md_result  in  32  multdiv result
- md_ready  in  1  multdiv result valid
- md_exception  in  1  multdiv overflow / divide-by-zero
- ctrl_mult, ctrl_div  out  1 each  one-cycle start pulses to multdiv
- md_a, md_b  out  32 each  held operands to multdiv
- stall  out  1  freeze PC/F/D/X, insert bubble into M
- result_valid  out  1  one-cycle completion strobe
- result_out  out  32  result for X/M latch
- rd_out  out  5  destination register
- exc_out  out  1  write rstatus this completion
- rstatus_code  out  32  4 for mul, 5 for div, else 0
- busy  out  1  state != IDLE

## Operation
- Decode: R-type when instruction_x[31:27]=00000.
  - ALU op instruction_x[6:2]=00110 is mul; 00111 is div.
  - rd = instruction_x[26:22].
- launch = IDLE & valid_x & ~flush_x & (mul|div).
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - On launch, latch md_a/md_b, rd, op into hold registers, then go to START.
  - stall = launch, driven combinationally in the launch cycle.
- START:
  - ctrl_mult or ctrl_div = 1 per latched op.
  - Clear counter; go to WAIT. stall = 1.
  - md_ready in START is ignored.
- WAIT: stall = 1; counter increments each cycle.
  - On md_ready: capture md_result and md_exception, go to DONE.
  - Otherwise, when counter = TIMEOUT-1: capture result 0 with exception 1, go to DONE.
  - md_ready and timeout in the same cycle: md_ready wins.
- DONE:
  - stall = 0; result_valid = 1; go to IDLE.
  - result_out, rd_out and exc_out come from the captures.
  - rstatus_code = 4 (mul) or 5 (div) when exc_out, else 0.
- Relaunch rule: the stalled instruction advances out of X on the DONE edge. IDLE therefore never relaunches it, so back-to-back mul/div start one cycle apart.
- Non-mul/div, bubbles and flushed instructions never leave IDLE and never assert stall.
- flush_x outside IDLE is ignored; an in-flight operation always completes.
- md_a/md_b stay stable from START through DONE.

## Timing
- Reset values:
  - state = IDLE.
  - All outputs 0: stall, busy, ctrl_mult, ctrl_div, result_valid, exc_out, result_out, rd_out, md_a, md_b, rstatus_code.
- Reset asserted mid-operation: immediate return to IDLE.
  - stall and the strobes drop asynchronously.
  - No result_valid is emitted.
- Launch cycle L: stall = 1 combinationally.
- L+1: start pulse.
- First md_ready at L+1+k (k ≥ 1) gives DONE at L+2+k, with result_valid high exactly one cycle.
- Stall is continuously high from L through L+1+k.
- Timeout with no ready: DONE at L+2+TIMEOUT.
- ctrl_mult and ctrl_div are never high together, and are never high outside START.

## Test plan
- mul: operand_a=6, operand_b=7; md_ready with md_result=42 three cycles after the ctrl_mult pulse -> stall high 5 cycles, result_valid one cycle with result_out=42, rd_out=instruction rd, exc_out=0.
- div 10/0: md_exception=1 with md_ready -> exc_out=1, rstatus_code=5, ctrl_div pulsed once, ctrl_mult never.
- Timeout: TIMEOUT=40, md_ready held low -> DONE 42 cycles after launch, result_out=0, exc_out=1, rstatus_code=4 for mul.
- Back-to-back mul then div: second start pulse follows the first DONE by exactly two cycles; operands captured independently.
- Reset low during WAIT -> same-cycle stall=0, busy=0; after reset release, a fresh mul completes normally.
- add (ALU op 00000), valid_x=0, or mul with flush_x=1 -> stall, busy and ctrl pulses stay 0.
